// File: rtl/calc_pkg.sv
// Shared calculator definitions: segment glyphs and helpers
// used by the display scanner.
package calc_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_E     = 7'b1001111;

  typedef enum logic [1:0] {
    GLYPH_DIGIT,
    GLYPH_BLANK,
    GLYPH_ERR
  } glyph_e;

  // Segments {a,b,c,d,e,f,g}, bit6 = a; non-BCD codes show '9'.
  function automatic logic [6:0] bcd2segments(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      default: s = 7'b1111011;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_polarity(
    input logic [6:0] seg,
    input logic       active_low
  );
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/calc_scan_timer.sv
// Slot and digit-position counters for the display scanner,
// with the per-slot anode blanking window and frame pulse.
module calc_scan_timer #(
  parameter int ScanDiv     = 1000,
  parameter int NumDigits   = 8,
  parameter int BlankCycles = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic [$clog2(NumDigits)-1:0] digit_o,
  output logic                         blank_o,
  output logic                         frame_o
);

  localparam int SW = $clog2(ScanDiv);
  localparam int DW = $clog2(NumDigits);

  localparam logic [SW-1:0] SLOT_LAST = SW'(ScanDiv - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NumDigits - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BlankCycles);

  logic [SW-1:0] slot_q, slot_d;
  logic [DW-1:0] digit_q, digit_d;

  // Slot counter wraps every ScanDiv cycles and steps the digit.
  always_comb begin
    slot_d  = slot_q + 1'b1;
    digit_d = digit_q;
    if (slot_q == SLOT_LAST) begin
      slot_d  = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      digit_q <= '0;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  assign blank_o = (slot_q < BLANK_END);
  assign frame_o = (slot_q == SLOT_LAST) && (digit_q == DIG_LAST);

endmodule

// File: rtl/calc_display_scan.sv
// Multiplexed 7-segment scanner with a frame-synchronous shadow
// copy of the displayed value and valid/ready loading.
module calc_display_scan
  import calc_pkg::*;
#(
  parameter int NumDigits      = 8,
  parameter int ScanDiv        = 1000,
  parameter int BlankCycles    = 2,
  parameter int SegActiveLow   = 0,
  parameter int AnodeActiveLow = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_valid_i,
  output logic                         load_ready_o,
  input  logic                         sign_i,
  input  logic                         error_i,
  input  logic [$clog2(NumDigits)-1:0] exponent_i,
  input  logic [NumDigits*4-1:0]       significand_i,
  output logic [6:0]                   seg_o,
  output logic                         dp_o,
  output logic [NumDigits-1:0]         an_o,
  output logic                         sign_o,
  output logic                         frame_o
);

  localparam int EW = $clog2(NumDigits);
  localparam int SGW = NumDigits * 4;

  localparam logic SEG_LOW = (SegActiveLow != 0);
  localparam logic AN_LOW  = (AnodeActiveLow != 0);

  localparam logic [6:0] SEG_OFF =
    SEG_LOW ? 7'h7F : 7'h00;
  localparam logic [NumDigits-1:0] AN_OFF =
    AN_LOW ? {NumDigits{1'b1}} : {NumDigits{1'b0}};

  logic [EW-1:0] digit;
  logic          blank;
  logic          frame;

  calc_scan_timer #(
    .ScanDiv    (ScanDiv),
    .NumDigits  (NumDigits),
    .BlankCycles(BlankCycles)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .digit_o(digit),
    .blank_o(blank),
    .frame_o(frame)
  );

  logic           pend_full_q, pend_full_d;
  logic           pend_sign_q, pend_sign_d;
  logic           pend_err_q,  pend_err_d;
  logic [EW-1:0]  pend_exp_q,  pend_exp_d;
  logic [SGW-1:0] pend_sig_q,  pend_sig_d;

  logic           shd_sign_q, shd_sign_d;
  logic           shd_err_q,  shd_err_d;
  logic [EW-1:0]  shd_exp_q,  shd_exp_d;
  logic [SGW-1:0] shd_sig_q,  shd_sig_d;

  logic                 accept;

  assign load_ready_o = ~pend_full_q;
  assign accept       = load_valid_i & ~pend_full_q;

  // Pending slot fills on accept; drains to shadow at frame end.
  always_comb begin
    pend_full_d = pend_full_q;
    pend_sign_d = pend_sign_q;
    pend_err_d  = pend_err_q;
    pend_exp_d  = pend_exp_q;
    pend_sig_d  = pend_sig_q;
    shd_sign_d  = shd_sign_q;
    shd_err_d   = shd_err_q;
    shd_exp_d   = shd_exp_q;
    shd_sig_d   = shd_sig_q;
    if (frame && pend_full_q) begin
      shd_sign_d  = pend_sign_q;
      shd_err_d   = pend_err_q;
      shd_exp_d   = pend_exp_q;
      shd_sig_d   = pend_sig_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_full_d = 1'b1;
      pend_sign_d = sign_i;
      pend_err_d  = error_i;
      pend_exp_d  = exponent_i;
      pend_sig_d  = significand_i;
    end
  end

  // Pending and shadow value registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_full_q <= 1'b0;
      pend_sign_q <= 1'b0;
      pend_err_q  <= 1'b0;
      pend_exp_q  <= '0;
      pend_sig_q  <= '0;
      shd_sign_q  <= 1'b0;
      shd_err_q   <= 1'b0;
      shd_exp_q   <= '0;
      shd_sig_q   <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_sign_q <= pend_sign_d;
      pend_err_q  <= pend_err_d;
      pend_exp_q  <= pend_exp_d;
      pend_sig_q  <= pend_sig_d;
      shd_sign_q  <= shd_sign_d;
      shd_err_q   <= shd_err_d;
      shd_exp_q   <= shd_exp_d;
      shd_sig_q   <= shd_sig_d;
    end
  end

  int         pos;
  int         ex;
  logic [3:0] cur_dig;
  logic       tail_zero;
  logic       frac_nz;
  logic       val_zero;
  logic       disp_err;

  // Digit under scan plus zero-tail and fraction summaries.
  always_comb begin
    pos       = int'(digit);
    ex        = int'(shd_exp_q);
    disp_err  = shd_err_q || (ex >= NumDigits);
    val_zero  = (shd_sig_q == '0);
    cur_dig   = '0;
    tail_zero = 1'b1;
    frac_nz   = 1'b0;
    for (int i = 0; i < NumDigits; i++) begin
      if (i == pos)
        cur_dig = shd_sig_q[(NumDigits-1-i)*4 +: 4];
      if (i >= pos &&
          shd_sig_q[(NumDigits-1-i)*4 +: 4] != 4'd0)
        tail_zero = 1'b0;
      if (i > ex &&
          shd_sig_q[(NumDigits-1-i)*4 +: 4] != 4'd0)
        frac_nz = 1'b1;
    end
  end

  glyph_e               glyph;
  logic [6:0]           seg_raw;
  logic                 dp_raw;
  logic                 sign_raw;
  logic [NumDigits-1:0] an_raw;

  // Glyph choice for the current position.
  always_comb begin
    glyph = GLYPH_DIGIT;
    unique case (1'b1)
      disp_err && pos == 0:
        glyph = GLYPH_ERR;
      disp_err && pos != 0:
        glyph = GLYPH_BLANK;
      !disp_err && pos > ex && tail_zero:
        glyph = GLYPH_BLANK;
      default:
        glyph = GLYPH_DIGIT;
    endcase
  end

  logic [6:0]           seg_q, seg_d;
  logic                 dp_q,  dp_d;
  logic [NumDigits-1:0] an_q,  an_d;
  logic                 sign_q, sign_d;

  // Raw (active-high) pin values, then pin polarity.
  always_comb begin
    case (glyph)
      GLYPH_ERR:   seg_raw = SEG_E;
      GLYPH_BLANK: seg_raw = SEG_BLANK;
      default:     seg_raw = bcd2segments(cur_dig);
    endcase
    dp_raw   = !disp_err && pos == ex && frac_nz;
    sign_raw = shd_sign_q && !disp_err && !val_zero;
    an_raw   = '0;
    for (int i = 0; i < NumDigits; i++)
      if (!blank && i == NumDigits - 1 - pos)
        an_raw[i] = 1'b1;
    seg_d  = seg_polarity(seg_raw, SEG_LOW);
    dp_d   = dp_raw ^ SEG_LOW;
    an_d   = AN_LOW ? ~an_raw : an_raw;
    sign_d = sign_raw;
  end

  // Output registers; reset turns every anode off at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg_q  <= SEG_OFF;
      dp_q   <= SEG_LOW;
      an_q   <= AN_OFF;
      sign_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      sign_q <= sign_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign sign_o  = sign_q;
  assign frame_o = frame;

endmodule

// File: tb/tb_calc_display_scan.sv
// Scoreboard bench: stimulus queues expected frames, a monitor
// captures each scanned frame and compares.
module tb_calc_display_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        lv, lr, sgn, err, seg_dp, so, frame;
  logic [2:0]  exp_i;
  logic [31:0] sig;
  logic [6:0]  seg;
  logic [7:0]  an;

  calc_display_scan #(
    .NumDigits(8), .ScanDiv(8), .BlankCycles(2),
    .SegActiveLow(0), .AnodeActiveLow(1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .load_valid_i(lv), .load_ready_o(lr),
    .sign_i(sgn), .error_i(err),
    .exponent_i(exp_i), .significand_i(sig),
    .seg_o(seg), .dp_o(seg_dp), .an_o(an),
    .sign_o(so), .frame_o(frame)
  );

  logic        lv6, lr6, sgn6, err6, dp6, so6, fr6;
  logic [2:0]  exp6;
  logic [23:0] sig6;
  logic [6:0]  seg6;
  logic [5:0]  an6;

  calc_display_scan #(
    .NumDigits(6), .ScanDiv(4), .BlankCycles(1),
    .SegActiveLow(1), .AnodeActiveLow(0)
  ) dut6 (
    .clk_i(clk), .rst_i(rst),
    .load_valid_i(lv6), .load_ready_o(lr6),
    .sign_i(sgn6), .error_i(err6),
    .exponent_i(exp6), .significand_i(sig6),
    .seg_o(seg6), .dp_o(dp6), .an_o(an6),
    .sign_o(so6), .frame_o(fr6)
  );

  typedef struct packed {
    logic [0:7][6:0] seg;
    logic [0:7]      dp;
    logic            sign;
  } frame_t;

  frame_t sb_q[$];
  int checks = 0;
  int failures = 0;
  logic done6 = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic frame_t mkf(input logic [55:0] s,
                                 input logic [7:0] d,
                                 input logic g);
    frame_t f;
    f.seg = s;
    f.dp = d;
    f.sign = g;
    return f;
  endfunction

  frame_t FZ, F2, F3A, F3B, F4, F0S, FA, FB;
  initial begin
    FZ  = mkf({7'h7E, {7{7'h00}}}, 8'h00, 1'b0);
    F2  = mkf({7'h30, 7'h6D, 7'h79, 7'h33,
               7'h5B, 7'h5F, 7'h70, 7'h7F}, 8'h20, 1'b1);
    F3A = mkf({7'h30, 7'h6D, {6{7'h00}}}, 8'h80, 1'b0);
    F3B = mkf({7'h30, 7'h6D, 7'h7E, 7'h7E,
               {4{7'h00}}}, 8'h00, 1'b0);
    F4  = mkf({7'h4F, {7{7'h00}}}, 8'h00, 1'b0);
    F0S = mkf({8{7'h7E}}, 8'h00, 1'b0);
    FA  = mkf({7'h7B, {6{7'h7E}}, 7'h30}, 8'h00, 1'b1);
    FB  = mkf({7'h7B, 7'h5B, {6{7'h00}}}, 8'h00, 1'b0);
  end

  logic [0:7][6:0] cap_seg;
  logic [0:7]      cap_dp, cap_sign, seen;
  logic            synced, have_last, fin_pend;
  int              idx, since, mp;
  logic [7:0]      an_req;
  frame_t          mon_e;

  // Monitor: per-cycle anode checks, frame capture and compare.
  always @(negedge clk) begin
    if (rst) begin
      seen = '0;
      synced = 1'b0;
      have_last = 1'b0;
      fin_pend = 1'b0;
    end else begin
      mp = -1;
      for (int i = 0; i < 8; i++)
        if (!an[i]) mp = 7 - i;
      chk("an_onehot", $countones(~an) <= 1, 1);
      if (synced) begin
        if (idx % 8 < 2) an_req = 8'hFF;
        else an_req = ~(8'h80 >> (idx / 8));
        chk("an_phase", an, an_req);
        idx++;
      end
      if (mp >= 0) begin
        cap_seg[mp] = seg;
        cap_dp[mp] = seg_dp;
        cap_sign[mp] = so;
        seen[mp] = 1'b1;
      end
      if (fin_pend) begin
        fin_pend = 1'b0;
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          chk("frame_seen", seen, 8'hFF);
          chk("frame_seg", cap_seg, mon_e.seg);
          chk("frame_dp", cap_dp, mon_e.dp);
          chk("frame_sign", cap_sign, {8{mon_e.sign}});
        end
        seen = '0;
        synced = 1'b1;
        idx = 0;
      end
      if (frame) begin
        if (have_last) chk("frame_period", since, 64);
        have_last = 1'b1;
        since = 0;
        fin_pend = 1'b1;
      end
      since++;
    end
  end

  task automatic drive(input logic [31:0] s, input logic [2:0] e,
                       input logic g, input logic r);
    sig = s;
    exp_i = e;
    sgn = g;
    err = r;
    lv = 1'b1;
  endtask

  task automatic load(input logic [31:0] s, input logic [2:0] e,
                      input logic g, input logic r);
    int n = 0;
    drive(s, e, g, r);
    while (!lr && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("load_accept", lr, 1);
    @(negedge clk);
    lv = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 300);
    chk("frame_wait", frame, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic show(input logic [31:0] s, input logic [2:0] e,
                      input logic g, input logic r,
                      input frame_t f);
    load(s, e, g, r);
    wait_frame();
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back(f);
    drain();
  endtask

  // Second instance: out-of-range exponent, inverted pin polarity.
  initial begin
    logic [6:0] seg6_req;
    logic e_seen = 1'b0;
    int n = 0;
    int p6;
    lv6 = 1'b0;
    sig6 = 24'h123456;
    exp6 = 3'd7;
    sgn6 = 1'b1;
    err6 = 1'b0;
    repeat (5) @(negedge clk);
    lv6 = 1'b1;
    while (!lr6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("nd6_accept", lr6, 1);
    @(negedge clk);
    lv6 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!fr6 && n < 100);
      chk("nd6_frame", fr6, 1);
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      chk("nd6_onehot", $countones(an6) <= 1, 1);
      for (int i = 0; i < 6; i++) begin
        if (an6[i]) begin
          p6 = 5 - i;
          seg6_req = (p6 == 0) ? ~7'h4F : 7'h7F;
          if (p6 == 0) e_seen = 1'b1;
          chk("nd6_seg", seg6, seg6_req);
          chk("nd6_dp", dp6, 1);
          chk("nd6_sign", so6, 0);
        end
      end
    end
    chk("nd6_e_seen", e_seen, 1);
    done6 = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bad;
    rst = 1'b1;
    lv = 1'b0;
    sig = '0;
    exp_i = '0;
    sgn = 1'b0;
    err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h00);
    chk("rst_dp", seg_dp, 0);
    chk("rst_sign", so, 0);
    chk("rst_frame", frame, 0);
    chk("rst_ready", lr, 1);
    rst = 1'b0;
    sb_q.push_back(FZ);
    sb_q.push_back(FZ);
    drain();

    show(32'h12345678, 3'd2, 1'b1, 1'b0, F2);
    show(32'h12000000, 3'd0, 1'b0, 1'b0, F3A);
    show(32'h12000000, 3'd3, 1'b0, 1'b0, F3B);
    show(32'h00000000, 3'd0, 1'b1, 1'b0, FZ);
    show(32'h12345678, 3'd2, 1'b1, 1'b1, F4);

    wait_frame();
    chk("bnd_ready", lr, 1);
    drive(32'h00000000, 3'd7, 1'b1, 1'b0);
    @(negedge clk);
    lv = 1'b0;
    chk("bnd_ready_drop", lr, 0);
    @(negedge clk);
    sb_q.push_back(F4);
    wait_frame();
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back(F0S);
    drain();

    drive(32'h90000001, 3'd7, 1'b1, 1'b0);
    chk("b2b_ready_a", lr, 1);
    @(negedge clk);
    drive(32'hA5000000, 3'd1, 1'b0, 1'b0);
    chk("b2b_ready_drop", lr, 0);
    n = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (lr) bad = 1'b1;
    end while (!frame && n < 300);
    chk("b2b_frame", frame, 1);
    chk("b2b_held_low", bad, 0);
    @(negedge clk);
    chk("b2b_ready_back", lr, 1);
    @(negedge clk);
    lv = 1'b0;
    sb_q.push_back(FA);
    wait_frame();
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back(FB);
    drain();

    load(32'h12345678, 3'd2, 1'b1, 1'b0);
    chk("mid_pending", lr, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_an", an, 8'hFF);
    chk("mid_ready", lr, 1);
    chk("mid_sign", so, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(FZ);
    sb_q.push_back(FZ);
    drain();

    n = 0;
    while (!done6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("nd6_done", done6, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
